// File: rtl/bitworks_logic_pkg.sv
// Shared types for the bitworks bitwise logic unit: operation encoding.
package bitworks_logic_pkg;

  localparam int OP_W = 3;

  // Every 3-bit code is a legal operation.
  typedef enum logic [OP_W-1:0] {
    OP_NAND   = 3'd0,
    OP_AND    = 3'd1,
    OP_OR     = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline register slice of the bitwise logic unit: holds a beat's
// valid bit, result data and its zero/ones flags.
module logic_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_zero,
  input  logic             prev_ones,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             ones
);

  // Slice register: flush only kills the valid bit, payload is left as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      zero  <= 1'b0;
      ones  <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= prev_valid;
      end
      if (load && !flush) begin
        data <= prev_data;
        zero <= prev_zero;
        ones <= prev_ones;
      end
    end
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with eight operations, result
// flags, a valid/ready handshake with full backpressure, and a saturating
// completion counter.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds inA/inB/op stable while in_valid && !in_ready;
// the unit holds outY/out_zero/out_ones stable while out_valid && !out_ready.
// in_ready depends combinationally on out_ready (no skid buffer).
module bitwise_logic_pipe
  import bitworks_logic_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  op_e                op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outY,
  output logic               out_zero,
  output logic               out_ones,
  output logic [COUNT_W-1:0] done_count
);

  logic [WIDTH-1:0]  res;
  logic              res_zero;
  logic              res_ones;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] st_valid;
  logic [WIDTH-1:0]  st_data [STAGES];
  logic [STAGES-1:0] st_zero;
  logic [STAGES-1:0] st_ones;
  logic              complete;

  // Operation decode on the incoming operands.
  always_comb begin
    res = '0;
    case (op)
      OP_NAND:   res = ~(inA & inB);
      OP_AND:    res = inA & inB;
      OP_OR:     res = inA | inB;
      OP_NOR:    res = ~(inA | inB);
      OP_XOR:    res = inA ^ inB;
      OP_XNOR:   res = ~(inA ^ inB);
      OP_NOT_A:  res = ~inA;
      OP_PASS_A: res = inA;
      default:   res = '0;
    endcase
  end

  assign res_zero = (res == '0);
  assign res_ones = (res == '1);

  // A stage may load when it is empty or everything downstream can move.
  // That is the same as: out_ready is high, or some stage at or after i is
  // empty. Written this way the ready path has no self-referencing chain.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign rdy[i] = out_ready || !(&st_valid[STAGES-1:i]);

    if (i == 0) begin : g_first
      logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (rdy[i]),
        .prev_valid (in_valid),
        .prev_data  (res),
        .prev_zero  (res_zero),
        .prev_ones  (res_ones),
        .valid      (st_valid[i]),
        .data       (st_data[i]),
        .zero       (st_zero[i]),
        .ones       (st_ones[i])
      );
    end else begin : g_rest
      logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (rdy[i]),
        .prev_valid (st_valid[i-1]),
        .prev_data  (st_data[i-1]),
        .prev_zero  (st_zero[i-1]),
        .prev_ones  (st_ones[i-1]),
        .valid      (st_valid[i]),
        .data       (st_data[i]),
        .zero       (st_zero[i]),
        .ones       (st_ones[i])
      );
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = st_valid[STAGES-1];
  assign outY      = st_data[STAGES-1];
  assign out_zero  = st_zero[STAGES-1];
  assign out_ones  = st_ones[STAGES-1];
  assign complete  = out_valid && out_ready;

  // Completion counter: counts output handshakes (even under flush) and
  // sticks at its maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (complete && (done_count != '1)) begin
      done_count <= done_count + COUNT_W'(1);
    end
  end

endmodule
